// File: rtl/address_latch_if.sv
// Control and flag bundle for the address latch; the sequencer holds the master side.
interface address_latch_if;
  logic ctl_al_we;
  logic ctl_al_inc_ld;
  logic ctl_inc_cy;
  logic ctl_inc_dec;
  logic ctl_inc_oe;
  logic ctl_ab_we;
  logic pin_ab_oe;
  logic inc_zero;
  logic inc_wrap;

  modport master (
    output ctl_al_we, ctl_al_inc_ld, ctl_inc_cy, ctl_inc_dec,
    output ctl_inc_oe, ctl_ab_we, pin_ab_oe,
    input  inc_zero, inc_wrap
  );

  modport slave (
    input  ctl_al_we, ctl_al_inc_ld, ctl_inc_cy, ctl_inc_dec,
    input  ctl_inc_oe, ctl_ab_we, pin_ab_oe,
    output inc_zero, inc_wrap
  );
endinterface

// File: rtl/address_latch.sv
// 16-bit address latch with +1/-1/+0 incrementer, bus write-back and address pin register.
// Zero/wrap flag registers are built only when ADDR_LATCH_FLAGS_EN is defined.
module address_latch (
  input  logic           clk,
  input  logic           nreset,
  address_latch_if.slave ctl,
  inout  wire  [7:0]     dbus_hi_as,
  inout  wire  [7:0]     dbus_lo_as,
  output wire  [15:0]    abus
);

  logic [15:0] al;
  logic [15:0] ab_q;
  logic [15:0] inc_res;
  logic [15:0] bus_in;
  logic        bus_oe;

  always_comb begin
    inc_res = al;
    if (ctl.ctl_inc_cy) begin
      inc_res = ctl.ctl_inc_dec ? (al - 16'd1) : (al + 16'd1);
    end
  end

  // Bus drivers stay released during reset even if the sequencer requests drive.
  assign bus_oe     = ctl.ctl_inc_oe & nreset;
  assign dbus_hi_as = bus_oe ? inc_res[15:8] : 8'hzz;
  assign dbus_lo_as = bus_oe ? inc_res[7:0]  : 8'hzz;
  assign bus_in     = {dbus_hi_as, dbus_lo_as};

  // While we drive the bus it carries our own result, so take it directly instead of reading back.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      al <= 16'h0000;
    end else if (ctl.ctl_al_we) begin
      al <= ctl.ctl_inc_oe ? inc_res : bus_in;
    end else if (ctl.ctl_al_inc_ld) begin
      al <= inc_res;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ab_q <= 16'h0000;
    end else if (ctl.ctl_ab_we) begin
      ab_q <= al;
    end
  end

  assign abus = ctl.pin_ab_oe ? ab_q : 16'hzzzz;

`ifdef ADDR_LATCH_FLAGS_EN
  logic zero_q;
  logic wrap_q;

  // Wrap is judged on the pre-step latch value and the step direction.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      zero_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (ctl.ctl_inc_cy) begin
      zero_q <= (inc_res == 16'h0000);
      wrap_q <= ctl.ctl_inc_dec ? (al == 16'h0000) : (al == 16'hFFFF);
    end
  end

  assign ctl.inc_zero = zero_q;
  assign ctl.inc_wrap = wrap_q;
`else
  assign ctl.inc_zero = 1'b0;
  assign ctl.inc_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_address_latch.sv
// Self-checking bench for address_latch: directed plan steps, then random control against an arithmetic model.
module tb_address_latch;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'h0000;
  wire  [7:0]  dbus_hi_as;
  wire  [7:0]  dbus_lo_as;
  wire  [15:0] abus;

  int errors = 0;
  int checks = 0;
  int m_al = 0;
  int m_ab = 0;
  int m_z = 0;
  int m_w = 0;

  always #5 clk = ~clk;

  address_latch_if ifc ();

  assign dbus_hi_as = drv_en ? drv_val[15:8] : 8'hzz;
  assign dbus_lo_as = drv_en ? drv_val[7:0]  : 8'hzz;

  // Released nets read as all-ones, which makes a tri-stated output observable.
  pullup (dbus_hi_as);
  pullup (dbus_lo_as);
  pullup (abus);

  address_latch dut (
    .clk        (clk),
    .nreset     (nreset),
    .ctl        (ifc),
    .dbus_hi_as (dbus_hi_as),
    .dbus_lo_as (dbus_lo_as),
    .abus       (abus)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkPins(input string tag);
    logic [15:0] exp_ab;
    exp_ab = ifc.pin_ab_oe ? m_ab[15:0] : 16'hFFFF;
    checkOutput({tag, "/abus"}, abus, exp_ab);
    checkOutput({tag, "/inc_zero"}, {15'd0, ifc.inc_zero}, m_z[15:0]);
    checkOutput({tag, "/inc_wrap"}, {15'd0, ifc.inc_wrap}, m_w[15:0]);
  endtask

  // One clock: drive at the falling edge, check the bus before the rising edge, check pins/flags after.
  task automatic applyStimulus(input string tag, input bit al_we, input bit inc_ld, input bit cy,
                               input bit dec, input bit inc_oe, input bit ab_we, input bit drv,
                               input logic [15:0] val);
    int res;
    ifc.ctl_al_we     = al_we;
    ifc.ctl_al_inc_ld = inc_ld;
    ifc.ctl_inc_cy    = cy;
    ifc.ctl_inc_dec   = dec;
    ifc.ctl_inc_oe    = inc_oe;
    ifc.ctl_ab_we     = ab_we;
    drv_en            = drv;
    drv_val           = val;
    #1;
    if (!cy)      res = m_al;
    else if (dec) res = (m_al + 65535) % 65536;
    else          res = (m_al + 1) % 65536;
    if (inc_oe)    checkOutput({tag, "/bus_result"}, {dbus_hi_as, dbus_lo_as}, res[15:0]);
    else if (!drv) checkOutput({tag, "/bus_released"}, {dbus_hi_as, dbus_lo_as}, 16'hFFFF);
    @(posedge clk);
    if (ab_we) m_ab = m_al;
`ifdef ADDR_LATCH_FLAGS_EN
    if (cy) begin
      m_z = (res == 0) ? 1 : 0;
      m_w = ((!dec && m_al == 65535) || (dec && m_al == 0)) ? 1 : 0;
    end
`endif
    if (al_we)       m_al = inc_oe ? res : int'(val);
    else if (inc_ld) m_al = res;
    #1;
    checkPins(tag);
    @(negedge clk);
    drv_en = 1'b0;
  endtask

  initial begin
    ifc.ctl_al_we     = 1'b0;
    ifc.ctl_al_inc_ld = 1'b0;
    ifc.ctl_inc_cy    = 1'b0;
    ifc.ctl_inc_dec   = 1'b0;
    ifc.ctl_inc_oe    = 1'b1;
    ifc.ctl_ab_we     = 1'b0;
    ifc.pin_ab_oe     = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/bus", {dbus_hi_as, dbus_lo_as}, 16'hFFFF);
    checkPins("reset");
    @(negedge clk);
    nreset = 1'b1;

    applyStimulus("load1234", 1, 0, 0, 0, 0, 0, 1, 16'h1234);
    applyStimulus("inc1234",  0, 0, 1, 0, 1, 1, 0, 16'h0000);
    checkOutput("abus_1234", abus, 16'h1234);

    applyStimulus("loadFFFF", 1, 0, 0, 0, 0, 0, 1, 16'hFFFF);
    applyStimulus("wrapinc",  0, 1, 1, 0, 0, 0, 0, 16'h0000);
    applyStimulus("read0000", 0, 0, 0, 0, 1, 1, 0, 16'h0000);
    applyStimulus("show0000", 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    checkOutput("abus_0000", abus, 16'h0000);

    applyStimulus("load0001", 1, 0, 0, 0, 0, 0, 1, 16'h0001);
    applyStimulus("dec1",     0, 1, 1, 1, 0, 0, 0, 16'h0000);
    applyStimulus("dec2",     0, 1, 1, 1, 0, 0, 0, 16'h0000);
    applyStimulus("readFFFF", 0, 0, 0, 0, 1, 1, 0, 16'h0000);

    applyStimulus("load0010", 1, 0, 0, 0, 0, 0, 1, 16'h0010);
    applyStimulus("prio",     1, 1, 1, 0, 0, 0, 1, 16'hABCD);
    applyStimulus("readABCD", 0, 0, 0, 0, 1, 0, 0, 16'h0000);
    applyStimulus("selfload", 1, 0, 1, 0, 1, 0, 0, 16'h0000);
    applyStimulus("readABCE", 0, 0, 0, 0, 1, 1, 0, 16'h0000);
    applyStimulus("weab",     1, 0, 0, 0, 0, 1, 1, 16'h5555);

    applyStimulus("load4000", 1, 0, 0, 0, 0, 0, 1, 16'h4000);
    applyStimulus("ab4000",   0, 0, 0, 0, 0, 1, 0, 16'h0000);
    ifc.pin_ab_oe = 1'b0;
    applyStimulus("pinoff",   0, 0, 0, 0, 0, 0, 0, 16'h0000);
    ifc.pin_ab_oe = 1'b1;
    applyStimulus("pinon",    0, 0, 0, 0, 0, 0, 0, 16'h0000);
    checkOutput("abus_4000", abus, 16'h4000);

    ifc.ctl_inc_oe = 1'b1;
    #2;
    nreset = 1'b0;
    #1;
    m_al = 0; m_ab = 0; m_z = 0; m_w = 0;
    checkOutput("midreset/bus", {dbus_hi_as, dbus_lo_as}, 16'hFFFF);
    checkPins("midreset");
    @(negedge clk);
    nreset = 1'b1;
    applyStimulus("postreset", 0, 0, 1, 1, 1, 0, 0, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      bit al_we, inc_ld, cy, dec, inc_oe, ab_we, drv;
      logic [15:0] val;
      al_we  = ($urandom_range(0, 3) == 0);
      inc_ld = $urandom_range(0, 1) == 1;
      cy     = $urandom_range(0, 3) != 0;
      dec    = $urandom_range(0, 1) == 1;
      inc_oe = $urandom_range(0, 2) == 0;
      ab_we  = $urandom_range(0, 1) == 1;
      drv    = !inc_oe && (al_we || $urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       val = 16'hFFFF;
        1:       val = 16'h0000;
        default: val = 16'($urandom());
      endcase
      ifc.pin_ab_oe = ($urandom_range(0, 3) != 0);
      applyStimulus("random", al_we, inc_ld, cy, dec, inc_oe, ab_we, drv, val);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
